// File: rtl/cp0_exception_controller_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, register layouts
// and the writeback-to-CP0 bundle.
package cp0_exception_controller_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exception_code_e;

    typedef struct packed {
        logic [4:0]  addr;
        logic [2:0]  select;
        logic        write_enabled;
        logic [31:0] write_data;
        logic        exception_valid;
        logic        eret_flish;
    } wb_to_cp0_data_t;

    typedef struct packed {
        logic [8:0] rsvd_hi;
        logic       bev;
        logic [5:0] rsvd_mid;
        logic [7:0] im;
        logic [5:0] rsvd_lo;
        logic       exl;
        logic       ie;
    } status_data_t;

    typedef struct packed {
        logic        bd;
        logic [14:0] rsvd_hi;
        logic [7:0]  ip;
        logic        rsvd_mid;
        logic [4:0]  exc_code;
        logic [1:0]  rsvd_lo;
    } cause_data_t;

    // Only address errors carry a meaningful faulting address.
    function automatic logic is_address_error(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_exception_controller_if.sv
// Bundle between the writeback stage / front end (master) and CP0 (slave).
interface cp0_exception_controller_if;
    import cp0_exception_controller_pkg::*;

    wb_to_cp0_data_t wb_to_cp0;
    logic [4:0]      exception_code;
    logic [31:0]     exception_pc;
    logic            exception_in_slot;
    logic [31:0]     exception_badvaddr;
    logic [5:0]      hardware_interrupt;
    logic [31:0]     read_data;
    logic            interrupt_request;
    logic            flush;
    logic [31:0]     flush_pc;

    modport master (
        output wb_to_cp0, exception_code, exception_pc, exception_in_slot,
               exception_badvaddr, hardware_interrupt,
        input  read_data, interrupt_request, flush, flush_pc
    );

    modport slave (
        input  wb_to_cp0, exception_code, exception_pc, exception_in_slot,
               exception_badvaddr, hardware_interrupt,
        output read_data, interrupt_request, flush, flush_pc
    );

endinterface

// File: rtl/cp0_exception_controller_timer.sv
// CP0 timer: prescaled Count, Compare and the sticky timer interrupt.
module cp0_timer #(
    parameter int unsigned COUNT_DIVIDE = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        count_write,
    input  logic        compare_write,
    input  logic [31:0] write_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_interrupt
);

    localparam int DIV_W = (COUNT_DIVIDE > 1) ? $clog2(COUNT_DIVIDE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIVIDE - 1);

    logic [DIV_W-1:0] divider_q, divider_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             ti_q, ti_d;
    logic             count_updated;

    // TI only latches when Count actually moves, so an idle match after reset stays quiet.
    always_comb begin
        divider_d     = divider_q;
        count_d       = count_q;
        compare_d     = compare_q;
        ti_d          = ti_q;
        count_updated = 1'b0;
        if (count_write) begin
            count_d       = write_data;
            divider_d     = '0;
            count_updated = 1'b1;
        end else if (divider_q == DIV_LAST) begin
            divider_d     = '0;
            count_d       = count_q + 32'd1;
            count_updated = 1'b1;
        end else begin
            divider_d = divider_q + 1'b1;
        end
        if (compare_write) begin
            compare_d = write_data;
            ti_d      = 1'b0;
        end else if (count_updated && (count_d == compare_d)) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            divider_q <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            divider_q <= divider_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count           = count_q;
    assign compare         = compare_q;
    assign timer_interrupt = ti_q;

endmodule

// File: rtl/cp0_exception_controller.sv
// Coprocessor-0 exception controller: Status/Cause/EPC/BadVAddr, write priority,
// MFC0 read mux, interrupt request and flush target selection.
module cp0_exception_controller
    import cp0_exception_controller_pkg::*;
#(
    parameter logic [31:0] EXCEPTION_VECTOR = 32'hBFC0_0380,
    parameter int unsigned COUNT_DIVIDE     = 2
) (
    input logic                         clock,
    input logic                         reset,
    cp0_exception_controller_if.slave   cp0
);

    wb_to_cp0_data_t wb;
    logic            mtc0_en;
    logic [31:0]     count, compare;
    logic            timer_interrupt;
    status_data_t    status_rd, wr_status;
    cause_data_t     cause_rd, wr_cause;
    logic [31:0]     read_data;

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        irq_q, irq_d;

    assign wb        = cp0.wb_to_cp0;
    assign wr_status = wb.write_data;
    assign wr_cause  = wb.write_data;
    // A same-cycle exception or ERET swallows the MTC0.
    assign mtc0_en   = wb.write_enabled && (wb.select == 3'd0)
                       && !wb.exception_valid && !wb.eret_flish;

    cp0_timer #(.COUNT_DIVIDE(COUNT_DIVIDE)) u_timer (
        .clock           (clock),
        .reset           (reset),
        .count_write     (mtc0_en && (wb.addr == CP0_COUNT)),
        .compare_write   (mtc0_en && (wb.addr == CP0_COMPARE)),
        .write_data      (wb.write_data),
        .count           (count),
        .compare         (compare),
        .timer_interrupt (timer_interrupt)
    );

    always_comb begin
        status_rd          = STATUS_RESET;
        status_rd.im       = im_q;
        status_rd.exl      = exl_q;
        status_rd.ie       = ie_q;
        cause_rd           = '0;
        cause_rd.bd        = bd_q;
        cause_rd.ip        = {ip_hw_q[5] | timer_interrupt, ip_hw_q[4:0], ip_sw_q};
        cause_rd.exc_code  = exc_code_q;
    end

    always_comb begin
        read_data = '0;
        if (wb.select == 3'd0) begin
            case (wb.addr)
                CP0_BADVADDR: read_data = badvaddr_q;
                CP0_COUNT:    read_data = count;
                CP0_COMPARE:  read_data = compare;
                CP0_STATUS:   read_data = status_rd;
                CP0_CAUSE:    read_data = cause_rd;
                CP0_EPC:      read_data = epc_q;
                default:      read_data = '0;
            endcase
        end
    end

    // Exception beats ERET beats MTC0; a nested exception keeps the original EPC/BD.
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        ip_sw_d    = ip_sw_q;
        ip_hw_d    = cp0.hardware_interrupt;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        irq_d      = ie_q && !exl_q && |(im_q & cause_rd.ip);
        if (wb.exception_valid) begin
            if (!exl_q) begin
                epc_d = cp0.exception_in_slot ? (cp0.exception_pc - 32'd4) : cp0.exception_pc;
                bd_d  = cp0.exception_in_slot;
            end
            exl_d      = 1'b1;
            exc_code_d = cp0.exception_code;
            if (is_address_error(cp0.exception_code)) begin
                badvaddr_d = cp0.exception_badvaddr;
            end
        end else if (wb.eret_flish) begin
            exl_d = 1'b0;
        end else if (mtc0_en) begin
            case (wb.addr)
                CP0_STATUS: begin
                    im_d  = wr_status.im;
                    exl_d = wr_status.exl;
                    ie_d  = wr_status.ie;
                end
                CP0_CAUSE: ip_sw_d = wr_cause.ip[1:0];
                CP0_EPC:   epc_d   = wb.write_data;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            irq_q      <= irq_d;
        end
    end

    assign cp0.read_data         = read_data;
    assign cp0.interrupt_request = irq_q;
    assign cp0.flush             = wb.exception_valid | wb.eret_flish;
    assign cp0.flush_pc          = wb.exception_valid ? EXCEPTION_VECTOR : epc_q;

endmodule
